ibr128_block_sequencer: RTL

Bus-master controller that runs one complete IBR128 block operation without software involvement. It takes a 128-bit block, a 128-bit key and a mode on a valid/ready request port, and writes them into the IBR128 register interface. It then starts the core, polls status and reads back the 128-bit result. It sits beside the AXI-to-IBR adapter path and drives the IBR128 wrapper's CS/Write/Read/Addr/WData/RData port directly, for DMA/streaming use.

---
 rtl/ibr128_block_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ibr128_block_sequencer.sv
// Runs one IBR128 block operation on the register port: optional key load, data load, start, status poll, result read.
// Latency 17 cycles from accept with key load (13 without, +2 per extra poll); req held off outside IDLE, result held until rsp_ready.
module ibr128_block_sequencer #(
    parameter logic [4:0] KEY_BASE  = 5'h00,
    parameter logic [4:0] DIN_BASE  = 5'h04,
    parameter logic [4:0] CTRL_ADDR = 5'h08,
    parameter logic [4:0] STAT_ADDR = 5'h09,
    parameter logic [4:0] DOUT_BASE = 5'h0C,
    parameter int         POLL_MAX  = 64
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] req_key,
    input  logic [127:0] req_din,
    input  logic         req_decrypt,
    input  logic         req_key_load,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_dout,
    output logic         rsp_timeout,
    output logic         busy,
    output logic         ibr_cs,
    output logic         ibr_write,
    output logic         ibr_read,
    output logic [4:0]   ibr_addr,
    output logic [31:0]  ibr_writedata,
    input  logic [31:0]  ibr_readdata
);
    localparam int PW = $clog2(POLL_MAX + 1);

    typedef enum logic [3:0] {
        IDLE, WR_KEY, WR_DIN, START, POLL_RD, POLL_CHK, RD_OUT, RD_LAST, RESP
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [127:0]   r_key;
    logic [127:0]   r_din;
    logic           r_dec;
    logic           r_key_loaded;
    logic [1:0]     r_cnt;
    logic [PW-1:0]  r_poll;
    logic [127:0]   r_dout;
    logic           r_tmo;
    logic [PW-1:0]  w_poll_inc;
    logic           w_poll_limit;
    logic           w_wr;
    logic           w_rd;

    assign w_poll_inc   = r_poll + 1'b1;
    assign w_poll_limit = (w_poll_inc == PW'(POLL_MAX));
    assign rsp_dout     = r_dout;
    assign rsp_timeout  = r_tmo;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (req_valid) w_next = (req_key_load || !r_key_loaded) ? WR_KEY : WR_DIN;
            WR_KEY:   if (r_cnt == 2'd3) w_next = WR_DIN;
            WR_DIN:   if (r_cnt == 2'd3) w_next = START;
            START:    w_next = POLL_RD;
            POLL_RD:  w_next = POLL_CHK;
            POLL_CHK: begin
                if (ibr_readdata[0])   w_next = RD_OUT;
                else if (w_poll_limit) w_next = RESP;
                else                   w_next = POLL_RD;
            end
            RD_OUT:   if (r_cnt == 2'd3) w_next = RD_LAST;
            RD_LAST:  w_next = RESP;
            RESP:     if (rsp_ready) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready     = (r_state == IDLE);
        busy          = (r_state != IDLE);
        rsp_valid     = (r_state == RESP);
        w_wr          = 1'b0;
        w_rd          = 1'b0;
        ibr_addr      = 5'd0;
        ibr_writedata = 32'd0;
        case (r_state)
            WR_KEY: begin
                w_wr          = 1'b1;
                ibr_addr      = KEY_BASE + {3'b000, r_cnt};
                ibr_writedata = r_key[{r_cnt, 5'b00000} +: 32];
            end
            WR_DIN: begin
                w_wr          = 1'b1;
                ibr_addr      = DIN_BASE + {3'b000, r_cnt};
                ibr_writedata = r_din[{r_cnt, 5'b00000} +: 32];
            end
            START: begin
                w_wr          = 1'b1;
                ibr_addr      = CTRL_ADDR;
                ibr_writedata = {30'd0, r_dec, 1'b1};
            end
            POLL_RD: begin
                w_rd     = 1'b1;
                ibr_addr = STAT_ADDR;
            end
            RD_OUT: begin
                w_rd     = 1'b1;
                ibr_addr = DOUT_BASE + {3'b000, r_cnt};
            end
            default: ;
        endcase
        ibr_write = w_wr;
        ibr_read  = w_rd;
        ibr_cs    = w_wr | w_rd;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_key        <= '0;
            r_din        <= '0;
            r_dec        <= 1'b0;
            r_key_loaded <= 1'b0;
            r_cnt        <= 2'd0;
            r_poll       <= '0;
            r_dout       <= '0;
            r_tmo        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (req_valid) begin
                    r_key <= req_key;
                    r_din <= req_din;
                    r_dec <= req_decrypt;
                    r_cnt <= 2'd0;
                end
                WR_KEY: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) r_key_loaded <= 1'b1;
                end
                WR_DIN: r_cnt <= r_cnt + 2'd1;
                START:  r_poll <= '0;
                POLL_CHK: begin
                    r_poll <= w_poll_inc;
                    if (!ibr_readdata[0] && w_poll_limit) begin
                        r_tmo  <= 1'b1;
                        r_dout <= '0;
                    end
                end
                // Read data lags its address by one cycle, so word cnt-1 lands while read cnt issues.
                RD_OUT: begin
                    if (r_cnt != 2'd0) r_dout[{r_cnt - 2'd1, 5'b00000} +: 32] <= ibr_readdata;
                    r_cnt <= r_cnt + 2'd1;
                end
                RD_LAST: r_dout[127:96] <= ibr_readdata;
                RESP:    if (rsp_ready) r_tmo <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
